mac_multiplier: RTL

- Sequential 16×16 unsigned shift-and-add multiply-accumulate.
- Computes Product = Multiplicand × Multiplier + Addend, one multiplier bit per clock.
- Inverse datapath of the team's sequential divider. Feeding it (Divisor, Quotient, Remainder) must reproduce the original Dividend. The block serves as the divider's self-check engine and as a general-purpose multiplier in the lab top level.
- St/Done start/completion protocol matches the divider's.

---
 rtl/mac_multiplier.sv | 111 +++++++++++
 1 files changed

// File: rtl/mac_multiplier.sv
// Sequential unsigned shift-and-add multiply-accumulate: Product = Multiplicand * Multiplier + Addend.
// Define MAC_MULTIPLIER_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mac_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               St,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    input  logic [WIDTH-1:0]   Addend,
    output logic [2*WIDTH-1:0] Product,
    output logic               Overflow,
    output logic               Busy,
    output logic               Done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc, acc_d;
    logic [2*WIDTH-1:0] mcand, mcand_d;
    logic [WIDTH-1:0]   mplr, mplr_d;
    logic [CW-1:0]      count, count_d;
    logic               overflow_d, busy_d, done_d;
    logic               last_iter;

`ifdef MAC_MULTIPLIER_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain to be consumed after this iteration.
    assign last_iter = (count == CW'(WIDTH - 1)) || (mplr[WIDTH-1:1] == '0);
`else
    assign last_iter = (count == CW'(WIDTH - 1));
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        acc_d   = acc;
        mcand_d = mcand;
        mplr_d  = mplr;
        count_d = count;
        busy_d  = Busy;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (St) begin
                    acc_d   = {{WIDTH{1'b0}}, Addend};
                    mcand_d = {{WIDTH{1'b0}}, Multiplicand};
                    mplr_d  = Multiplier;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Worst case all-ones inputs still fit in 2*WIDTH bits, so no carry out.
                if (mplr[0]) acc_d = acc + mcand;
                mcand_d = mcand << 1;
                mplr_d  = mplr >> 1;
                count_d = count + CW'(1);
                if (last_iter) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        overflow_d = |acc_d[2*WIDTH-1:WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            count    <= '0;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc      <= acc_d;
            mcand    <= mcand_d;
            mplr     <= mplr_d;
            count    <= count_d;
            Overflow <= overflow_d;
            Busy     <= busy_d;
            Done     <= done_d;
        end
    end

    assign Product = acc;

endmodule
